// File: rtl/conv_pkg.sv
// Shared types for the 5x5 convolution window scheduler.
package conv_pkg;

  localparam int K = 5;

  typedef logic signed [7:0]  pixel_t;
  typedef logic signed [31:0] acc_t;
  typedef pixel_t [K-1:0][K-1:0] window_t;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT, DONE} sched_state_t;

endpackage

// File: rtl/conv_window_buf.sv
// 5x5 window register file: single-pixel writes, plus a one-column left shift
// when built with CONV_WIN_REUSE_EN.
module conv_window_buf
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_r,
  input  logic [2:0] wr_c,
  input  pixel_t     wr_data,
`ifdef CONV_WIN_REUSE_EN
  input  logic       shift_en,
`endif
  output window_t    win
);

  // Shift has priority; the scheduler never shifts and writes in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win <= '0;
`ifdef CONV_WIN_REUSE_EN
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
`endif
    end else if (wr_en) begin
      win[wr_r][wr_c] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Walks a stride-1, unpadded 5x5 window over one feature map, drives the conv
// unit and streams results out. CONV_WIN_REUSE_EN enables column reuse.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter  int IMG_W = 32,
  parameter  int IMG_H = 32,
  parameter  int AW    = $clog2(IMG_W*IMG_H),
  localparam int OUT_W = IMG_W-4,
  localparam int OUT_H = IMG_H-4,
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          layer_done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  pixel_t        mem_rdata,
  output window_t       win,
  output logic          conv_start,
  input  logic          conv_done,
  input  acc_t          conv_result,
  output logic          out_valid,
  input  logic          out_ready,
  output acc_t          out_data,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col
);

`ifdef CONV_WIN_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  sched_state_t state, state_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [4:0]    cnt;
  logic [2:0]    rd_r, rd_c, cap_r, cap_c;
  logic          cap_en, partial;
  logic [4:0]    last_cnt;
  logic          last_col, last_row;

  assign last_cnt = partial ? 5'd5 : 5'd25;
  assign last_col = (col == CW'(OUT_W-1));
  assign last_row = (row == RW'(OUT_H-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    busy       = 1'b1;
    layer_done = 1'b0;
    conv_start = 1'b0;
    out_valid  = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = LOAD;
      end
      LOAD: begin
        mem_rd_en = (cnt < last_cnt);
        if (cnt == last_cnt) state_n = START;
      end
      START: begin
        conv_start = 1'b1;
        state_n    = WAIT;
      end
      WAIT: if (conv_done) state_n = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = (last_col && last_row) ? DONE : LOAD;
      end
      DONE: begin
        layer_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mem_addr = mem_rd_en
                  ? (AW'(row) + AW'(rd_r)) * AW'(IMG_W) + AW'(col) + AW'(rd_c)
                  : '0;

  // Read data returns one cycle late, so the target (r,c) is delayed alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      row      <= '0;
      col      <= '0;
      cnt      <= '0;
      rd_r     <= '0;
      rd_c     <= '0;
      cap_en   <= 1'b0;
      cap_r    <= '0;
      cap_c    <= '0;
      partial  <= 1'b0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else begin
      cap_en <= mem_rd_en;
      cap_r  <= rd_r;
      cap_c  <= rd_c;
      case (state)
        IDLE: if (start) begin
          row     <= '0;
          col     <= '0;
          cnt     <= '0;
          rd_r    <= '0;
          rd_c    <= '0;
          partial <= 1'b0;
        end
        LOAD: begin
          cnt <= cnt + 5'd1;
          if (mem_rd_en) begin
            if (rd_c == 3'd4) begin
              rd_r <= rd_r + 3'd1;
              rd_c <= partial ? 3'd4 : 3'd0;
            end else begin
              rd_c <= rd_c + 3'd1;
            end
          end
        end
        WAIT: if (conv_done) begin
          out_data <= conv_result;
          out_row  <= row;
          out_col  <= col;
        end
        OUT: if (out_ready) begin
          cnt  <= '0;
          rd_r <= '0;
          if (!last_col) begin
            col     <= col + CW'(1);
            partial <= REUSE;
            rd_c    <= REUSE ? 3'd4 : 3'd0;
          end else begin
            col     <= '0;
            partial <= 1'b0;
            rd_c    <= 3'd0;
            if (!last_row) row <= row + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  conv_window_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cap_en),
    .wr_r     (cap_r),
    .wr_c     (cap_c),
    .wr_data  (mem_rdata),
`ifdef CONV_WIN_REUSE_EN
    .shift_en (state == LOAD && cnt == 5'd0 && partial),
`endif
    .win      (win)
  );

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched on a 6x6 map with a behavioural
// RAM and conv unit; CONV_WIN_REUSE_EN selects the expected read count.
module tb_conv_window_sched;
  import conv_pkg::*;

  localparam int W = 6;
`ifdef CONV_WIN_REUSE_EN
  localparam int EXP_RD = 60;
`else
  localparam int EXP_RD = 100;
`endif

  typedef struct { bit ones_img; bit ones_w; int exp_data[4]; } vec_t;
  typedef struct { int row; int col; int data; } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, layer_done, mem_rd_en, conv_start, conv_done, out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] mem_addr;
  pixel_t     mem_rdata = '0;
  window_t    win;
  acc_t       conv_result, out_data, model_sum = '0;
  logic [0:0] out_row, out_col;

  bit ones_img = 1'b0, ones_w = 1'b0, stray = 1'b0;
  logic [2:0] lat = '0;
  logic       model_done = 1'b0;

  int n_checks = 0, n_errors = 0;
  int n_out = 0, n_rd = 0, n_done = 0;
  exp_t exp_q[$];
  int   addr_log[$];
  vec_t vecs[3];

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(W), .IMG_H(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .layer_done(layer_done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .win(win),
    .conv_start(conv_start), .conv_done(conv_done), .conv_result(conv_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  // Single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ones_img ? 8'sd1 : pixel_t'(mem_addr);
  end

  function automatic int win_sum(window_t w);
    int s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        if (ones_w || (r == 2 && c == 2)) s += int'(w[r][c]);
    return s;
  endfunction

  // Conv unit model: result appears a few cycles after conv_start.
  always @(posedge clk) begin
    if (rst) begin
      lat        <= '0;
      model_done <= 1'b0;
    end else begin
      model_done <= (lat == 3'd1);
      if (conv_start) begin
        lat       <= 3'd3;
        model_sum <= win_sum(win);
      end else if (lat != 3'd0) begin
        lat <= lat - 3'd1;
      end
    end
  end

  assign conv_done   = model_done | stray;
  assign conv_result = stray ? 32'sd999 : model_sum;

  task automatic checkOutput(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (rst) return;
    if (layer_done) n_done++;
    if (mem_rd_en) begin
      n_rd++;
      if (addr_log.size() < 25) addr_log.push_back(int'(mem_addr));
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", int'(out_data), e.data);
        checkOutput("out_row", int'(out_row), e.row);
        checkOutput("out_col", int'(out_col), e.col);
      end
    end
  endtask

  // Samples at the falling edge, returns 1 time unit after the rising edge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(int v);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.row  = i / 2;
      e.col  = i % 2;
      e.data = vecs[v].exp_data[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(int v);
    ones_img = vecs[v].ones_img;
    ones_w   = vecs[v].ones_w;
    addr_log.delete();
    pushExpected(v);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic waitDone(int done0);
    int k = 0;
    while (n_done == done0 && k < 3000) begin
      cycle();
      k++;
    end
    if (k >= 3000) checkOutput("layer_timeout", 0, 1);
    checkOutput("busy_after_done", int'(busy), 0);
    repeat (4) cycle();
    checkOutput("layer_done_pulses", n_done - done0, 1);
  endtask

  task automatic runLayer(int v, bit poke);
    int out0 = n_out, rd0 = n_rd, done0 = n_done;
    applyStimulus(v);
    checkOutput("busy_running", int'(busy), 1);
    if (poke) begin
      repeat (20) cycle();
      start = 1'b1; cycle(); start = 1'b0;
      repeat (40) cycle();
      start = 1'b1; cycle(); start = 1'b0;
    end
    waitDone(done0);
    checkOutput("output_count", n_out - out0, 4);
    checkOutput("read_count", n_rd - rd0, EXP_RD);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int nz, k, done0;
    vecs[0].ones_img = 1'b0; vecs[0].ones_w = 1'b0; vecs[0].exp_data = '{14, 15, 20, 21};
    vecs[1].ones_img = 1'b1; vecs[1].ones_w = 1'b1; vecs[1].exp_data = '{25, 25, 25, 25};
    vecs[2].ones_img = 1'b0; vecs[2].ones_w = 1'b1; vecs[2].exp_data = '{350, 375, 500, 525};

    repeat (3) cycle();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_layer_done", int'(layer_done), 0);
    checkOutput("rst_mem_rd_en", int'(mem_rd_en), 0);
    checkOutput("rst_mem_addr", int'(mem_addr), 0);
    checkOutput("rst_conv_start", int'(conv_start), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_pos", int'({out_row, out_col}), 0);
    nz = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        if (win[r][c] != 0) nz++;
    checkOutput("rst_win_nonzero", nz, 0);
    rst = 1'b0;
    cycle();

    for (int v = 0; v < 3; v++) begin
      $display("[TB] layer with vector %0d", v);
      runLayer(v, 1'b0);
      if (v == 1) begin
        checkOutput("addr_log_len", addr_log.size(), 25);
        for (int i = 0; i < addr_log.size(); i++)
          checkOutput("first_window_addr", addr_log[i], (i / 5) * W + (i % 5));
      end
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    done0 = n_done;
    applyStimulus(0);
    k = 0;
    while (!out_valid && k < 500) begin
      cycle();
      k++;
    end
    if (k >= 500) checkOutput("out_valid_timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      stray = (i == 4);
      cycle();
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_out_data", int'(out_data), 14);
      checkOutput("bp_out_pos", int'({out_row, out_col}), 0);
      checkOutput("bp_mem_rd_en", int'(mem_rd_en), 0);
      checkOutput("bp_conv_start", int'(conv_start), 0);
    end
    stray = 1'b0;
    out_ready = 1'b1;
    waitDone(done0);
    checkOutput("bp_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] reset during WAIT");
    done0 = n_done;
    applyStimulus(0);
    k = 0;
    while (!conv_start && k < 500) begin
      cycle();
      k++;
    end
    if (k >= 500) checkOutput("conv_start_timeout", 0, 1);
    cycle();
    rst = 1'b1;
    cycle();
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_conv_start", int'(conv_start), 0);
    checkOutput("abort_layer_done", int'(layer_done), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) cycle();
    checkOutput("abort_no_done_pulse", n_done - done0, 0);
    runLayer(0, 1'b0);

    $display("[TB] start while busy");
    runLayer(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequences the 5x5 conv unit across one input feature map, stride 1, no padding.
- Fetches pixels from a single-port feature-map RAM and assembles the 5x5 window. Then pulses conv start, captures the 32-bit sum and hands it downstream over a valid/ready stream.
- Sits between the feature-map buffer and the layer's output writer; weights are driven to the conv unit elsewhere.

Parameters:
- IMG_W, 32, input map width in pixels (>= 5)
- IMG_H, 32, input map height in pixels (>= 5)
- AW, $clog2(IMG_W*IMG_H), RAM address width
- Derived localparams: OUT_W = IMG_W-4, OUT_H = IMG_H-4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- layer_done  out  1  one-cycle pulse after last output handshake
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  AW  pixel address, row-major: y*IMG_W + x
- mem_rdata  in  8 signed  read data, valid exactly 1 cycle after mem_rd_en
- win  out  [4:0][4:0] x 8 signed  window to conv inputs; win[r][c] = pixel(row+r, col+c)
- conv_start  out  1  one-cycle pulse to conv unit
- conv_done  in  1  conv completion pulse
- conv_result  in  32 signed  conv accumulator, valid when conv_done
- out_valid  out  1  result available
- out_ready  in  1  downstream accept
- out_data  out  32 signed  captured conv_result
- out_row  out  $clog2(OUT_H)  output row index of out_data
- out_col  out  $clog2(OUT_W)  output column index of out_data

Behaviour:
- Reset: state IDLE; row=col=0; win all 0. Also zero: busy, layer_done, mem_rd_en, mem_addr, conv_start, out_valid, out_data, out_row, out_col. Reset mid-operation aborts immediately, with no layer_done pulse. The conv unit shares rst.
- IDLE: on start -> LOAD. row=0, col=0.
- LOAD: issues 25 reads, one per cycle, in window raster order (r major, then c). Address = (row+r)*IMG_W + col + c. Each mem_rdata is written into win[r][c] one cycle after its read. The state exits after the 25th datum is captured: 26 cycles, with mem_rd_en high for the first 25.
- START: conv_start=1 for exactly one cycle -> WAIT.
- WAIT: win held stable; no reads. On conv_done: out_data<=conv_result, out_row<=row, out_col<=col, out_valid<=1 -> OUT.
- OUT: out_valid and out_data/out_row/out_col held until out_valid&&out_ready. On handshake, out_valid<=0 and the position advances:
  - If col<OUT_W-1: col++, -> LOAD.
  - Else if row<OUT_H-1: col=0, row++, -> LOAD.
  - Else -> DONE.
- DONE: layer_done=1 for one cycle -> IDLE.
- start while busy is ignored.
- conv_done outside WAIT is ignored.
- Output order is strictly raster (row major), OUT_W*OUT_H results per layer.
- Address arithmetic uses AW bits; the maximum address is IMG_W*IMG_H-1, and no wrap occurs for legal parameters.

Optional Feature:
- CONV_WIN_REUSE_EN defined: when advancing within a row (new col>0), LOAD shifts win left one column (win[r][c]<=win[r][c+1]). It then reads only the 5 new pixels of column 4, r=0..4, at addresses (row+r)*IMG_W + col + 4. LOAD lasts 6 cycles with 5 reads. Row starts still perform the full 25-read load.
- Undefined: every window is a full 25-read load.
- Results are bit-identical either way.

Decomposition:
- Package conv_pkg:
  - localparam K=5
  - typedef pixel_t (signed 8) and acc_t (signed 32)
  - typedef window_t (pixel_t [K-1:0][K-1:0])
  - enum sched_state_t {IDLE, LOAD, START, WAIT, OUT, DONE}
- One sub-module, conv_window_buf: holds the window registers and implements the write of (r,c,data) plus the shift-left operation under the _EN macro.
- The FSM and address generation stay in conv_window_sched.

Test Plan:
- Common setup, unless a scenario says otherwise: IMG_W=IMG_H=6; RAM pixel = address; weights have only centre=1; out_ready held high; behavioural conv model.
- Raster order: start -> exactly 4 outputs, (0,0)=14, (0,1)=15, (1,0)=20, (1,1)=21. Then one layer_done pulse, then busy=0.
- All-ones image with all-ones weights -> every out_data=25. The first window's mem_addr sequence is 0,1,2,3,4,6,7,...,28.
- Backpressure: drop out_ready for 10 cycles during OUT. out_valid, out_data and out_row/out_col must stay constant, with no mem_rd_en and no conv_start. Once ready, the result sequence is unchanged.
- Reset while in WAIT: busy, out_valid and conv_start go to 0 next cycle, with no layer_done. A following start produces the full correct 4-result sequence.
- Start pulsed while busy -> no restart; total outputs = 4.
- Read count: mem_rd_en high-cycle count = 100 without CONV_WIN_REUSE_EN, and 60 with it. Outputs must match the first scenario in both builds.
